// File: rtl/wb_rr_arb4.sv
// Four-master round-robin Wishbone arbiter for the shared conbus, holding each grant for the full cycle.
// Define ARB_TIMEOUT_EN to build the per-transaction watchdog (mask, to_ack, to_flag).
//
// state | meaning
// IDLE  | no owner, gnt = 0; picks the next eligible requester after `last`
// GRANT | owner gnt_id holds the bus until it drops req (or the watchdog fires)
module wb_rr_arb4 #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] req,
    input  logic       bus_ack,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       to_ack,
    output logic       to_flag,
    input  logic       to_clr
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_n;
    logic [3:0] gnt_n;
    logic [1:0] gnt_id_n;
    logic [1:0] last, last_n;
    logic [3:0] elig;
    logic [1:0] sel;
    logic [1:0] idx;
    logic       sel_ok;
    logic       owner_req;
    logic       drop_gnt;

    assign owner_req = req[gnt_id];
    assign gnt_valid = |gnt;

`ifdef ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

    logic [3:0]           mask, mask_n;
    logic [TIMEOUT_W-1:0] wd_cnt, wd_cnt_n;
    logic                 to_ack_n, to_flag_n;
    logic                 expire;

    assign elig     = req & ~mask;
    // A release in the same cycle as expiry is a normal release: no substitute ack.
    assign expire   = (state == GRANT) && owner_req && (wd_cnt == WD_LAST) && !bus_ack;
    assign drop_gnt = !owner_req || expire;
`else
    logic unused_wd_inputs;

    assign unused_wd_inputs = &{1'b0, bus_ack, to_clr};
    assign elig     = req;
    assign drop_gnt = !owner_req;
    assign to_ack   = 1'b0;
    assign to_flag  = 1'b0;
`endif

    // Rotating scan: first eligible index starting at last+1, wrapping.
    always_comb begin
        sel    = 2'd0;
        sel_ok = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!sel_ok && elig[idx]) begin
                sel    = idx;
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        last_n   = last;
        case (state)
            IDLE: begin
                if (sel_ok) begin
                    state_n  = GRANT;
                    gnt_n    = 4'b0001 << sel;
                    gnt_id_n = sel;
                    last_n   = sel;
                end
            end
            GRANT: begin
                if (drop_gnt) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= IDLE;
            gnt    <= 4'b0000;
            gnt_id <= 2'd0;
            last   <= 2'd3;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
            last   <= last_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        mask_n    = mask & req;
        to_ack_n  = 1'b0;
        to_flag_n = to_flag & ~to_clr;
        if (state != GRANT || bus_ack) begin
            wd_cnt_n = '0;
        end else begin
            wd_cnt_n = wd_cnt + 1'b1;
        end
        // Set beats a simultaneous to_clr.
        if (expire) begin
            to_ack_n     = 1'b1;
            to_flag_n    = 1'b1;
            mask_n[gnt_id] = 1'b1;
            wd_cnt_n     = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mask    <= 4'b0000;
            wd_cnt  <= '0;
            to_ack  <= 1'b0;
            to_flag <= 1'b0;
        end else begin
            mask    <= mask_n;
            wd_cnt  <= wd_cnt_n;
            to_ack  <= to_ack_n;
            to_flag <= to_flag_n;
        end
    end
`endif

endmodule

// File: tb/tb_wb_rr_arb4.sv
// Directed bench for wb_rr_arb4 with TIMEOUT=4; watchdog scenarios run only when ARB_TIMEOUT_EN is defined.
module tb_wb_rr_arb4;

    logic       sys_clk;
    logic       sys_rst;
    logic [3:0] req;
    logic       bus_ack;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       to_ack;
    logic       to_flag;
    logic       to_clr;

    int n_vec = 0;
    int n_err = 0;

    wb_rr_arb4 #(.TIMEOUT_W(8), .TIMEOUT(4)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .bus_ack  (bus_ack),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .to_ack   (to_ack),
        .to_flag  (to_flag),
        .to_clr   (to_clr)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic test_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        n_vec++; if (gnt_id !== 2'd0) begin n_err++; $display("FAIL reset_gnt_id got %0d want 0", gnt_id); end
        n_vec++; if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_gnt_valid got %b want 0", gnt_valid); end
        n_vec++; if (to_ack !== 1'b0 || to_flag !== 1'b0) begin n_err++; $display("FAIL reset_to got ack=%b flag=%b want 0/0", to_ack, to_flag); end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL idle_after_reset got %b want 0000", gnt); end
    endtask

    // All four request continuously; each owner keeps 2 cycles then drops req for one.
    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            @(negedge sys_clk);
            n_vec++; if (gnt !== (4'b0001 << order[s]) || gnt_id !== 2'(order[s]) || gnt_valid !== 1'b1) begin
                n_err++; $display("FAIL rotation_grant step %0d got gnt=%b id=%0d want gnt=%b id=%0d", s, gnt, gnt_id, 4'b0001 << order[s], order[s]);
            end
            @(negedge sys_clk);
            n_vec++; if (gnt !== (4'b0001 << order[s])) begin
                n_err++; $display("FAIL rotation_hold step %0d got %b want %b", s, gnt, 4'b0001 << order[s]);
            end
            req = 4'b1111 & ~(4'b0001 << order[s]);
            @(negedge sys_clk);
            n_vec++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
                n_err++; $display("FAIL rotation_gap step %0d got gnt=%b valid=%b want 0000/0", s, gnt, gnt_valid);
            end
            req = 4'b1111;
        end
        req = 4'b0000;
        @(negedge sys_clk);
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rotation_end got %b want 0000", gnt); end
    endtask

    // last = 0 here: 0101 must pick 2, then 0; master 1 never appears.
    task automatic test_skip();
        req = 4'b0101;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin n_err++; $display("FAIL skip_first got gnt=%b id=%0d want 0100/2", gnt, gnt_id); end
        req = 4'b0001;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL skip_gap got %b want 0000", gnt); end
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin n_err++; $display("FAIL skip_second got gnt=%b id=%0d want 0001/0", gnt, gnt_id); end
        req = 4'b0000;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL skip_end got %b want 0000", gnt); end
    endtask

    // last = 0: owner 1 keeps the bus for 40 cycles against req[0]; ack every 3rd cycle keeps the 4-cycle watchdog quiet.
    task automatic test_hold_with_ack();
        req = 4'b0011;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            n_vec++; if (gnt !== 4'b0010 || to_ack !== 1'b0) begin
                n_err++; $display("FAIL hold_ack cycle %0d got gnt=%b to_ack=%b want 0010/0", i, gnt, to_ack);
            end
            bus_ack = (i % 3 == 2);
        end
        bus_ack = 1'b0;
        req = 4'b0000;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000 || to_flag !== 1'b0) begin n_err++; $display("FAIL hold_ack_end got gnt=%b flag=%b want 0000/0", gnt, to_flag); end
    endtask

`ifdef ARB_TIMEOUT_EN
    // last = 1: owner 2 never sees an ack, watchdog fires after 4 granted cycles.
    task automatic test_timeout();
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            n_vec++; if (gnt !== 4'b0100 || to_ack !== 1'b0) begin
                n_err++; $display("FAIL timeout_granted cycle %0d got gnt=%b to_ack=%b want 0100/0", i, gnt, to_ack);
            end
        end
        @(negedge sys_clk);
        n_vec++; if (to_ack !== 1'b1 || gnt !== 4'b0000 || to_flag !== 1'b1) begin
            n_err++; $display("FAIL timeout_fire got to_ack=%b gnt=%b flag=%b want 1/0000/1", to_ack, gnt, to_flag);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            n_vec++; if (to_ack !== 1'b0 || gnt !== 4'b0000 || to_flag !== 1'b1) begin
                n_err++; $display("FAIL timeout_masked cycle %0d got to_ack=%b gnt=%b flag=%b want 0/0000/1", i, to_ack, gnt, to_flag);
            end
        end
        req = 4'b0000;
        @(negedge sys_clk);
        req = 4'b0100;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0100 || to_flag !== 1'b1) begin n_err++; $display("FAIL timeout_regrant got gnt=%b flag=%b want 0100/1", gnt, to_flag); end
        to_clr = 1'b1;
        @(negedge sys_clk);
        to_clr = 1'b0;
        n_vec++; if (to_flag !== 1'b0) begin n_err++; $display("FAIL timeout_clr got flag=%b want 0", to_flag); end
        req = 4'b0000;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000 || to_ack !== 1'b0) begin n_err++; $display("FAIL timeout_end got gnt=%b to_ack=%b want 0000/0", gnt, to_ack); end
    endtask
`else
    // last = 1: owner 2 with no ack keeps the bus indefinitely.
    task automatic test_no_watchdog();
        to_clr = 1'b1;
        req = 4'b0100;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            n_vec++; if (gnt !== 4'b0100 || to_ack !== 1'b0 || to_flag !== 1'b0) begin
                n_err++; $display("FAIL nowd_hold cycle %0d got gnt=%b to_ack=%b flag=%b want 0100/0/0", i, gnt, to_ack, to_flag);
            end
        end
        to_clr = 1'b0;
        req = 4'b0000;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL nowd_end got %b want 0000", gnt); end
    endtask
`endif

    // last = 2: owner 3, ack lands exactly on the 4th (expiry) cycle.
    task automatic test_ack_at_expiry();
        req = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            n_vec++; if (gnt !== 4'b1000 || to_ack !== 1'b0) begin
                n_err++; $display("FAIL ackexp_pre cycle %0d got gnt=%b to_ack=%b want 1000/0", i, gnt, to_ack);
            end
            bus_ack = (i == 3);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            bus_ack = 1'b0;
            n_vec++; if (gnt !== 4'b1000 || to_ack !== 1'b0 || to_flag !== 1'b0) begin
                n_err++; $display("FAIL ackexp_post cycle %0d got gnt=%b to_ack=%b flag=%b want 1000/0/0", i, gnt, to_ack, to_flag);
            end
        end
        req = 4'b0000;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000 || to_ack !== 1'b0) begin n_err++; $display("FAIL ackexp_end got gnt=%b to_ack=%b want 0000/0", gnt, to_ack); end
    endtask

    // last = 3: owner 3 granted, reset pulsed between edges, then lowest requester (1) wins.
    task automatic test_async_reset();
        req = 4'b1000;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL arst_pre got %b want 1000", gnt); end
        #2 sys_rst = 1'b1;
        #1;
        n_vec++; if (gnt !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0) begin
            n_err++; $display("FAIL arst_immediate got gnt=%b id=%0d valid=%b want 0000/0/0", gnt, gnt_id, gnt_valid);
        end
        req = 4'b1010;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin n_err++; $display("FAIL arst_first_grant got gnt=%b id=%0d want 0010/1", gnt, gnt_id); end
        req = 4'b0000;
        @(negedge sys_clk);
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL arst_end got %b want 0000", gnt); end
    endtask

    initial begin
        sys_rst = 1'b1;
        req     = 4'b0000;
        bus_ack = 1'b0;
        to_clr  = 1'b0;
        test_reset();
        test_rotation();
        test_skip();
        test_hold_with_ack();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_watchdog();
`endif
        test_ack_at_expiry();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
